// File: rtl/reset_seq_pkg.sv
// reset_seq_pkg: shared state encoding and timer sizing for reset_sequencer.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_RELEASE = 2'd1,
    ST_DONE    = 2'd2,
    ST_DRAIN   = 2'd3
  } state_t;

  // Timer width able to hold the larger of the two load values.
  function automatic int cnt_w(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/reset_seq_timer.sv
// reset_seq_timer: loadable down-counter that saturates at zero.
module reset_seq_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         expired
);

  // Load has priority; decrement stops at zero so the count never wraps.
  always_ff @(posedge clk) begin
    if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: ordered release of N_CH reset channels (channel 0 first)
// after a minimum assertion width, with a gap between releases and a
// per-channel hold that stalls the sequence.
// Optional macro RESET_SEQ_REVASSERT_EN: a software request in ST_DONE
// re-asserts the channels in reverse order (ST_DRAIN) instead of all at once.
//
// state      | meaning
// ST_ASSERT  | all channels asserted, counting the minimum assertion width
// ST_RELEASE | releasing channel o_stage once the gap elapsed and its hold is low
// ST_DONE    | all channels released
// ST_DRAIN   | re-asserting channels N_CH-1 down to 0 (macro builds only)
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int MIN_ASSERT = 4,
  parameter int STAGE_DLY  = 3
) (
  input  logic                       clk,
  input  logic                       i_rst,
  input  logic                       i_req,
  input  logic [N_CH-1:0]            i_hold,
  output logic [N_CH-1:0]            o_rst,
  output logic                       o_done,
  output logic [$clog2(N_CH+1)-1:0]  o_stage
);

  localparam int STG_W = $clog2(N_CH + 1);
  localparam int CNT_W = cnt_w(MIN_ASSERT, STAGE_DLY);
  localparam logic [CNT_W-1:0] MIN_VAL  = CNT_W'(MIN_ASSERT);
  localparam logic [CNT_W-1:0] DLY_VAL  = CNT_W'(STAGE_DLY);
  localparam logic [STG_W-1:0] LAST_STG = STG_W'(N_CH - 1);

  state_t            state, state_nxt;
  logic [STG_W-1:0]  stage_nxt;
  logic [N_CH-1:0]   rst_nxt;
  logic              done_nxt;
  logic              tmr_load, tmr_en, tmr_expired;
  logic [CNT_W-1:0]  tmr_val, tmr_cnt;
  logic              gap_over, hold_cur, req_all;

  reset_seq_timer #(.W(CNT_W)) u_timer (
    .clk      (clk),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .count    (tmr_cnt),
    .expired  (tmr_expired)
  );

  // The gap timer is loaded at the release edge, so the gap ends on the edge
  // where it would reach zero (or has already saturated there during a hold).
  assign gap_over = tmr_expired || (tmr_cnt == CNT_W'(1));

`ifdef RESET_SEQ_REVASSERT_EN
  assign req_all = i_req && (state != ST_DONE) && (state != ST_DRAIN);
`else
  assign req_all = i_req;
`endif

  // Hold of the channel next in line; holds of released channels are ignored.
  always_comb begin
    hold_cur = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (o_stage == STG_W'(i)) hold_cur = i_hold[i];
    end
  end

  // Next-state, next-output and timer control.
  always_comb begin
    state_nxt = state;
    stage_nxt = o_stage;
    rst_nxt   = o_rst;
    done_nxt  = o_done;
    tmr_load  = 1'b0;
    tmr_val   = MIN_VAL;
    tmr_en    = 1'b0;
    if (i_rst || req_all) begin
      state_nxt = ST_ASSERT;
      stage_nxt = '0;
      rst_nxt   = '1;
      done_nxt  = 1'b0;
      tmr_load  = 1'b1;
    end else begin
      case (state)
        ST_ASSERT: begin
          if (tmr_expired) begin
            rst_nxt[0] = 1'b0;
            stage_nxt  = STG_W'(1);
            if (N_CH == 1) begin
              done_nxt  = 1'b1;
              state_nxt = ST_DONE;
            end else begin
              state_nxt = ST_RELEASE;
              tmr_load  = 1'b1;
              tmr_val   = DLY_VAL;
            end
          end else begin
            tmr_en = 1'b1;
          end
        end
        ST_RELEASE: begin
          if (gap_over && !hold_cur) begin
            for (int i = 0; i < N_CH; i++) begin
              if (o_stage == STG_W'(i)) rst_nxt[i] = 1'b0;
            end
            stage_nxt = o_stage + STG_W'(1);
            if (o_stage == LAST_STG) begin
              done_nxt  = 1'b1;
              state_nxt = ST_DONE;
            end else begin
              tmr_load = 1'b1;
              tmr_val  = DLY_VAL;
            end
          end else begin
            tmr_en = 1'b1;
          end
        end
        ST_DONE: begin
`ifdef RESET_SEQ_REVASSERT_EN
          if (i_req) begin
            rst_nxt[N_CH-1] = 1'b1;
            stage_nxt       = LAST_STG;
            done_nxt        = 1'b0;
            tmr_load        = 1'b1;
            if (N_CH == 1) begin
              state_nxt = ST_ASSERT;
              tmr_val   = MIN_VAL;
            end else begin
              state_nxt = ST_DRAIN;
              tmr_val   = DLY_VAL;
            end
          end
`endif
        end
`ifdef RESET_SEQ_REVASSERT_EN
        ST_DRAIN: begin
          if (gap_over) begin
            for (int i = 0; i < N_CH; i++) begin
              if (o_stage == STG_W'(i + 1)) rst_nxt[i] = 1'b1;
            end
            stage_nxt = o_stage - STG_W'(1);
            tmr_load  = 1'b1;
            if (o_stage == STG_W'(1)) begin
              state_nxt = ST_ASSERT;
              tmr_val   = MIN_VAL;
            end else begin
              tmr_val = DLY_VAL;
            end
          end else begin
            tmr_en = 1'b1;
          end
        end
`endif
        default: begin
          state_nxt = ST_ASSERT;
          stage_nxt = '0;
          rst_nxt   = '1;
          done_nxt  = 1'b0;
          tmr_load  = 1'b1;
        end
      endcase
    end
  end

  // State and output registers; outputs come straight from these flops.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state   <= ST_ASSERT;
      o_stage <= '0;
      o_rst   <= '1;
      o_done  <= 1'b0;
    end else begin
      state   <= state_nxt;
      o_stage <= stage_nxt;
      o_rst   <= rst_nxt;
      o_done  <= done_nxt;
    end
  end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Parametrised reset release sequencer for one clock domain. It takes the already-synchronised block reset and releases `N_CH` downstream reset channels in fixed order (channel 0 first), with the following guarantees:
- a minimum assertion width;
- a programmable gap between channel releases;
- a per-channel hold that stalls the sequence.

It also accepts a synchronous software reset request. It sits directly after the reset synchroniser, feeding subsystem resets.

## Interface
- `N_CH`, 4 — number of output reset channels; ≥1.
- `MIN_ASSERT`, 4 — minimum cycles all channels stay asserted after reset/request removal; ≥1.
- `STAGE_DLY`, 3 — cycles between consecutive channel releases; ≥1.

- `clk` in 1 — clock.
- `i_rst` in 1 — reset, synchronous, active-high.
- `i_req` in 1 — software reset request, level, active-high.
- `i_hold` in N_CH — per-channel release hold, active-high.
- `o_rst` in/out: out N_CH — channel resets, active-high, registered.
- `o_done` out 1 — all channels released.
- `o_stage` out $clog2(N_CH+1) — number of channels currently released.

## Operation
- States: `ST_ASSERT`, `ST_RELEASE`, `ST_DONE`, `ST_DRAIN` (`ST_DRAIN` exists only with the configuration macro).
- **Reset.** While `i_rst` is sampled high:
  - `o_rst`=all 1, `o_done`=0, `o_stage`=0;
  - state `ST_ASSERT`, timer loaded with `MIN_ASSERT`.
- **`ST_ASSERT`.** Timer decrements only on edges where `i_rst`=0 and `i_req`=0. Any high sample reloads it. When it expires, `o_rst[0]` deasserts and the block enters `ST_RELEASE` with timer=`STAGE_DLY`.
- **`ST_RELEASE`.**
  - When the timer expires, channel k=`o_stage` deasserts.
  - If `i_hold[k]` is sampled high at that edge, the release defers to the first edge sampling it low. `STAGE_DLY` for channel k+1 counts from the actual release edge.
  - `o_stage` increments on each release.
  - Releasing channel `N_CH-1` sets `o_done` at the same edge and enters `ST_DONE`.
- **Hold scope.** `i_hold[k]` is ignored once channel k is released.
- **`i_req`.** Sampled high in `ST_RELEASE` or `ST_DONE`:
  - next edge: `o_rst`=all 1, `o_done`=0, `o_stage`=0, state `ST_ASSERT`;
  - behaviour in `ST_DONE` changes with the macro, see Configuration.
- **Priority.** `i_rst` > `i_req` > timer/hold. Simultaneous `i_rst` and `i_req` behave as `i_rst`.
- **Width rule.** Timer width is $clog2(max(`MIN_ASSERT`,`STAGE_DLY`)+1). It saturates at 0 and never wraps.

## Timing
- **Reference edge.** E0 = first edge sampling `i_rst`=0 and `i_req`=0 after assertion.
- **Release times, no holds:** `o_rst[k]` falls at E0+`MIN_ASSERT`+k·`STAGE_DLY`.
- **`o_done`** rises at the same edge as `o_rst[N_CH-1]` falls.
- **Assertion latency:** one edge from `i_rst` or `i_req` sampled high.
- **Outputs** come directly from flops; no combinational input→output paths.
- **`N_CH`=1:** `o_done` rises with `o_rst[0]` at E0+`MIN_ASSERT`.

## Configuration
- **Macro:** `RESET_SEQ_REVASSERT_EN`.
- **Defined — `i_req` in `ST_DONE`:**
  - enters `ST_DRAIN` and `o_done` falls next edge;
  - `o_rst[N_CH-1]` asserts at the next edge;
  - `o_rst[k]` asserts (N_CH-1-k)·`STAGE_DLY` edges later;
  - after channel 0 asserts, the block enters `ST_ASSERT`.
- **Defined — during `ST_DRAIN`:**
  - `i_req` is ignored;
  - `i_hold` is ignored;
  - `i_rst` still forces immediate all-assert;
  - `o_stage` decrements per channel asserted.
- **Not defined:** `i_req` in `ST_DONE` asserts all channels at once, as in `ST_RELEASE`.
- **In both builds,** `i_rst` asserts all channels at once.

## Structure
- **Package `reset_seq_pkg`:**
  - `state_t` enum (`ST_ASSERT`, `ST_RELEASE`, `ST_DONE`, `ST_DRAIN`);
  - function `cnt_w(a,b)` returning the timer width.
- **Sub-module `reset_seq_timer`:**
  - loadable down-counter with `load`, `en`, `expired`;
  - saturating at zero;
  - parameterised by width.
- Top holds the FSM, stage index, `o_rst` vector and hold gating.

## Test plan
Default parameters (`N_CH`=4, `MIN_ASSERT`=4, `STAGE_DLY`=3) unless noted.
- **Power-up sequence:** `i_rst` 1 for 5 cycles, then 0 (E0).
  - `o_rst[0..3]` fall at E0+4, +7, +10, +13.
  - `o_done` rises at E0+13.
  - `o_stage` steps 1→4.
- **Hold stall:** `i_hold[2]`=1 from E0 to E0+20.
  - `o_rst[2]` falls at the first edge sampling it 0 (≈E0+21).
  - `o_rst[3]` falls 3 edges later.
  - `o_rst[0..1]` are unaffected.
- **Request mid-sequence:** `i_req` pulse 1 cycle at E0+8.
  - All `o_rst`=1 at E0+9 and `o_stage`=0.
  - `o_rst[0]` re-releases 4 edges after `i_req` is sampled low.
- **Reset priority:** `i_rst` and `i_req` both 1 in `ST_DONE`, then `i_rst` held 2 cycles.
  - All asserted next edge.
  - Release times match power-up relative to the new E0.
  - With macro: no staggered drain.
- **Reverse drain (macro defined):** `i_req` pulse in `ST_DONE`.
  - `o_rst[3]` at +1, `o_rst[2]` at +4, `o_rst[1]` at +7, `o_rst[0]` at +10.
  - Then releases after `MIN_ASSERT`.
  - `i_req` pulses during the drain have no effect.
- **Minimum config:** `N_CH`=1, `MIN_ASSERT`=1.
  - `o_rst[0]` and `o_done` toggle at E0+1.
  - Toggling `i_req` each cycle keeps `o_rst` asserted continuously.
